awg_sample_sequencer: RTL and testbench

- Sequences playback of packed 16-bit AWG samples from a 32-bit-wide waveform BRAM. Two samples per word; the low half is the even sample.
- Generates the BRAM read address, the half-select ("odd") and the valid/strobe for the downstream word-to-sample composer.
- Supports one-shot or continuous playback, a per-sample hold divider and period-boundary pulses.
- Sits between the control registers and the waveform BRAM/composer in the DAC path.

---
 rtl/awg_sample_sequencer.sv | 132 +++++++++++++
 tb/tb_awg_sample_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/awg_sample_sequencer.sv
// AWG sample sequencer: walks packed 16-bit samples in a 32-bit waveform BRAM and feeds the composer.
// Optional period counter enabled by defining AWG_SEQ_PERIOD_COUNT_EN; otherwise period_count is tied to 0.
//
// state    | meaning
// ST_IDLE  | waiting for an accepted start, BRAM disabled
// ST_RUN   | stepping through samples, one BRAM read per cycle
module awg_sample_sequencer #(
    parameter int ADDR_W = 14
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [ADDR_W:0]   num_samples,
    input  logic [15:0]       hold_div,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [31:0]       bram_rdata,
    output logic [31:0]       word_out,
    output logic              odd,
    output logic              wave_valid,
    output logic              sample_stb,
    output logic              period_stb,
    output logic              busy,
    output logic              done,
    output logic [31:0]       period_count
);

    localparam logic [0:0]      ST_IDLE = 1'b0;
    localparam logic [0:0]      ST_RUN  = 1'b1;
    localparam logic [ADDR_W:0] ONE_S   = {{ADDR_W{1'b0}}, 1'b1};

    logic [0:0]      state;
    logic [ADDR_W:0] s;
    logic [ADDR_W:0] n_l;
    logic [15:0]     h;
    logic [15:0]     hold_l;
    logic            cont_l;

    logic start_ok;
    logic hold_end;
    logic last_sample;
    logic period_end;

    assign start_ok    = (state == ST_IDLE) && start && !stop && (num_samples != '0);
    assign hold_end    = (h == hold_l);
    assign last_sample = (s == (n_l - ONE_S));
    // A stop in the same cycle as the final advance aborts: no done, no period credit.
    assign period_end  = (state == ST_RUN) && !stop && hold_end && last_sample;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state  <= ST_IDLE;
            s      <= '0;
            h      <= '0;
            n_l    <= '0;
            hold_l <= '0;
            cont_l <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        n_l    <= num_samples;
                        hold_l <= hold_div;
                        cont_l <= continuous;
                        s      <= '0;
                        h      <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        s     <= '0;
                        h     <= '0;
                        state <= ST_IDLE;
                    end else if (hold_end) begin
                        h <= '0;
                        if (last_sample) begin
                            s <= '0;
                            if (!cont_l) begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            s <= s + ONE_S;
                        end
                    end else begin
                        h <= h + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bram_en   = (state == ST_RUN);
    assign busy      = (state == ST_RUN);
    assign bram_addr = s[ADDR_W:1];
    assign word_out  = bram_rdata;

    // One register stage lines the sideband up with the BRAM's read latency.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wave_valid <= 1'b0;
            odd        <= 1'b0;
            sample_stb <= 1'b0;
            period_stb <= 1'b0;
            done       <= 1'b0;
        end else begin
            wave_valid <= bram_en;
            odd        <= s[0];
            sample_stb <= bram_en && (h == '0);
            period_stb <= bram_en && (h == '0) && (s == '0);
            done       <= period_end && !cont_l;
        end
    end

`ifdef AWG_SEQ_PERIOD_COUNT_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            period_count <= '0;
        end else if (start_ok) begin
            period_count <= '0;
        end else if (period_end) begin
            period_count <= period_count + 32'd1;
        end
    end
`else
    assign period_count = '0;
`endif

endmodule

// File: tb/tb_awg_sample_sequencer.sv
// Directed self-checking bench for awg_sample_sequencer with a 1-cycle-latency BRAM model.
module tb_awg_sample_sequencer;

    localparam int ADDR_W = 14;

    logic              aclk;
    logic              areset;
    logic              start;
    logic              stop;
    logic              continuous;
    logic [ADDR_W:0]   num_samples;
    logic [15:0]       hold_div;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic [31:0]       bram_rdata;
    logic [31:0]       word_out;
    logic              odd;
    logic              wave_valid;
    logic              sample_stb;
    logic              period_stb;
    logic              busy;
    logic              done;
    logic [31:0]       period_count;

    int errors = 0;
    int checks = 0;

    awg_sample_sequencer #(.ADDR_W(ADDR_W)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .start        (start),
        .stop         (stop),
        .continuous   (continuous),
        .num_samples  (num_samples),
        .hold_div     (hold_div),
        .bram_addr    (bram_addr),
        .bram_en      (bram_en),
        .bram_rdata   (bram_rdata),
        .word_out     (word_out),
        .odd          (odd),
        .wave_valid   (wave_valid),
        .sample_stb   (sample_stb),
        .period_stb   (period_stb),
        .busy         (busy),
        .done         (done),
        .period_count (period_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Word k holds even sample 0xA000+2k low and odd sample 0xB000+2k+1 high.
    function automatic logic [31:0] mem_word(input int k);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'(32'hA000 + 2 * k);
        hi = 16'(32'hB000 + 2 * k + 1);
        return {hi, lo};
    endfunction

    always @(posedge aclk) begin
        if (bram_en) bram_rdata <= mem_word(int'(bram_addr));
    end

    function automatic logic [31:0] pc_exp(input int v);
`ifdef AWG_SEQ_PERIOD_COUNT_EN
        return 32'(v);
`else
        return 32'(v * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sidx;
        int hpos;
        areset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        num_samples = '0; hold_div = '0; bram_rdata = '0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_en", 32'(bram_en), 0);
        chk("rst_valid", 32'(wave_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(bram_addr), 0);
        chk("rst_pc", period_count, 0);
        areset = 1'b0;
        tick();

        // one-shot N=4, hold 0
        num_samples = 4; hold_div = 0; continuous = 0; start = 1;
        tick(); start = 0;
        chk("t1_c1_busy", 32'(busy), 1);
        chk("t1_c1_en", 32'(bram_en), 1);
        chk("t1_c1_addr", 32'(bram_addr), 0);
        chk("t1_c1_valid", 32'(wave_valid), 0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk("t1_valid", 32'(wave_valid), 1);
            chk("t1_odd", 32'(odd), 32'((c - 2) & 1));
            chk("t1_sstb", 32'(sample_stb), 1);
            chk("t1_pstb", 32'(period_stb), 32'(c == 2));
            chk("t1_word", word_out, mem_word((c - 2) >> 1));
            chk("t1_done", 32'(done), 32'(c == 5));
            chk("t1_busy", 32'(busy), 32'(c != 5));
            if (c < 5) chk("t1_addr", 32'(bram_addr), 32'((c - 1) >> 1));
        end
        tick();
        chk("t1_c6_valid", 32'(wave_valid), 0);
        chk("t1_c6_done", 32'(done), 0);
        chk("t1_pc", period_count, pc_exp(1));

        // continuous N=3, hold 2, three periods then stop
        num_samples = 3; hold_div = 2; continuous = 1; start = 1;
        tick(); start = 0;
        for (int c = 2; c <= 28; c++) begin
            tick();
            sidx = ((c - 2) / 3) % 3;
            hpos = (c - 2) % 3;
            chk("t2_valid", 32'(wave_valid), 1);
            chk("t2_odd", 32'(odd), 32'(sidx & 1));
            chk("t2_sstb", 32'(sample_stb), 32'(hpos == 0));
            chk("t2_pstb", 32'(period_stb), 32'((c - 2) % 9 == 0));
            chk("t2_word", word_out, mem_word(sidx >> 1));
            chk("t2_addr", 32'(bram_addr), 32'((((c - 1) / 3) % 3) >> 1));
            chk("t2_done", 32'(done), 0);
            if (c == 10) chk("t2_pc1", period_count, pc_exp(1));
            if (c == 19) chk("t2_pc2", period_count, pc_exp(2));
            if (c == 28) chk("t2_pc3", period_count, pc_exp(3));
        end
        stop = 1;
        tick(); stop = 0;
        chk("t2_stop_busy", 32'(busy), 0);
        chk("t2_trail_valid", 32'(wave_valid), 1);
        chk("t2_trail_odd", 32'(odd), 0);
        chk("t2_stop_done", 32'(done), 0);
        tick();
        chk("t2_after_valid", 32'(wave_valid), 0);
        chk("t2_after_done", 32'(done), 0);
        chk("t2_pc_hold", period_count, pc_exp(3));

        // continuous N=8, stop 5 cycles in
        num_samples = 8; hold_div = 0; continuous = 1; start = 1;
        tick(); start = 0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk("t3_valid", 32'(wave_valid), 1);
            chk("t3_odd", 32'(odd), 32'((c - 2) & 1));
            chk("t3_done", 32'(done), 0);
        end
        stop = 1;
        tick(); stop = 0;
        chk("t3_busy", 32'(busy), 0);
        chk("t3_trail_valid", 32'(wave_valid), 1);
        chk("t3_trail_odd", 32'(odd), 0);
        chk("t3_done6", 32'(done), 0);
        chk("t3_pc", period_count, pc_exp(0));
        tick();
        chk("t3_valid7", 32'(wave_valid), 0);
        chk("t3_en7", 32'(bram_en), 0);
        chk("t3_done7", 32'(done), 0);
        tick();
        chk("t3_done8", 32'(done), 0);

        // start with N=0
        num_samples = 0; continuous = 0; start = 1;
        tick(); start = 0;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_en", 32'(bram_en), 0);
        tick();
        chk("t4_valid", 32'(wave_valid), 0);
        chk("t4_done", 32'(done), 0);

        // start and stop together
        num_samples = 4; start = 1; stop = 1;
        tick(); start = 0; stop = 0;
        chk("t5_busy", 32'(busy), 0);
        tick();
        chk("t5_valid", 32'(wave_valid), 0);
        chk("t5_done", 32'(done), 0);

        // start during RUN is ignored, mid-run parameter changes have no effect
        num_samples = 4; hold_div = 0; continuous = 0; start = 1;
        tick(); start = 0;
        tick();
        start = 1; num_samples = 2; continuous = 1; hold_div = 5;
        chk("t6_c2_odd", 32'(odd), 0);
        chk("t6_c2_valid", 32'(wave_valid), 1);
        tick(); start = 0;
        chk("t6_c3_odd", 32'(odd), 1);
        chk("t6_c3_addr", 32'(bram_addr), 1);
        chk("t6_c3_sstb", 32'(sample_stb), 1);
        tick();
        chk("t6_c4_odd", 32'(odd), 0);
        chk("t6_c4_word", word_out, mem_word(1));
        tick();
        chk("t6_c5_odd", 32'(odd), 1);
        chk("t6_c5_done", 32'(done), 1);
        chk("t6_c5_busy", 32'(busy), 0);
        tick();
        chk("t6_c6_valid", 32'(wave_valid), 0);

        // async reset mid-run
        num_samples = 6; hold_div = 0; continuous = 0; start = 1;
        tick(); start = 0;
        repeat (3) tick();
        chk("t7_pre_addr", 32'(bram_addr), 1);
        areset = 1;
        #1;
        chk("t7_busy", 32'(busy), 0);
        chk("t7_en", 32'(bram_en), 0);
        chk("t7_addr", 32'(bram_addr), 0);
        chk("t7_valid", 32'(wave_valid), 0);
        chk("t7_odd", 32'(odd), 0);
        chk("t7_sstb", 32'(sample_stb), 0);
        chk("t7_pstb", 32'(period_stb), 0);
        chk("t7_done", 32'(done), 0);
        chk("t7_pc", period_count, 0);
        tick();
        areset = 0;
        tick();
        start = 1;
        tick(); start = 0;
        chk("t7r_busy", 32'(busy), 1);
        chk("t7r_addr", 32'(bram_addr), 0);
        tick();
        chk("t7r_valid", 32'(wave_valid), 1);
        chk("t7r_odd", 32'(odd), 0);
        chk("t7r_pstb", 32'(period_stb), 1);
        chk("t7r_word", word_out, mem_word(0));
        for (int c = 3; c <= 7; c++) begin
            tick();
            chk("t7r_done", 32'(done), 32'(c == 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
